// File: rtl/bp_gshare.sv
// Gshare direction predictor: PC word-index XOR global history selects a saturating counter.
// Optional direct-mapped BTB enabled by defining BP_BTB_EN.
module bp_gshare #(
  parameter int unsigned INDEX_WIDTH     = 8,
  parameter int unsigned CNT_WIDTH       = 2,
  parameter int unsigned HIST_WIDTH      = 8,
  parameter int unsigned BTB_INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   in_fetch_ce,
  input  logic [31:0]            in_fetch_pc,
  output logic                   out_pred_taken,
  output logic [INDEX_WIDTH-1:0] out_pred_idx,
  output logic                   out_btb_hit,
  output logic [31:0]            out_btb_target,
  input  logic                   in_rob_ce,
  input  logic [INDEX_WIDTH-1:0] in_rob_idx,
  input  logic                   in_rob_taken,
  input  logic [31:0]            in_rob_pc,
  input  logic [31:0]            in_rob_target,
  input  logic                   in_flush
);

  localparam int unsigned ENTRIES = 2 ** INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

  logic [CNT_WIDTH-1:0]   pht [ENTRIES];
  logic [HIST_WIDTH-1:0]  spec_ghr;
  logic [HIST_WIDTH-1:0]  commit_ghr;
  logic [HIST_WIDTH-1:0]  commit_ghr_nxt;
  logic [INDEX_WIDTH-1:0] fetch_idx;
  logic [CNT_WIDTH-1:0]   rob_cnt;
  logic [CNT_WIDTH-1:0]   rob_cnt_nxt;

  assign fetch_idx      = in_fetch_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(spec_ghr);
  assign out_pred_idx   = fetch_idx;
  assign out_pred_taken = pht[fetch_idx][CNT_WIDTH-1];

  // Truncating {ghr, bit} to HIST_WIDTH is the shift-in; it also covers HIST_WIDTH == 1.
  always_comb begin
    commit_ghr_nxt = commit_ghr;
    if (in_rob_ce) begin
      commit_ghr_nxt = HIST_WIDTH'({commit_ghr, in_rob_taken});
    end
  end

  always_comb begin
    rob_cnt     = pht[in_rob_idx];
    rob_cnt_nxt = rob_cnt;
    if (in_rob_taken) begin
      if (rob_cnt != CNT_MAX) rob_cnt_nxt = rob_cnt + CNT_WIDTH'(1);
    end else begin
      if (rob_cnt != '0) rob_cnt_nxt = rob_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= CNT_RST;
    end else if (rdy && in_rob_ce) begin
      pht[in_rob_idx] <= rob_cnt_nxt;
    end
  end

  // A flush adopts the committed history including any branch retiring in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr   <= '0;
      commit_ghr <= '0;
    end else if (rdy) begin
      commit_ghr <= commit_ghr_nxt;
      if (in_flush) begin
        spec_ghr <= commit_ghr_nxt;
      end else if (in_fetch_ce) begin
        spec_ghr <= HIST_WIDTH'({spec_ghr, out_pred_taken});
      end
    end
  end

`ifdef BP_BTB_EN
  localparam int unsigned BTB_ENTRIES = 2 ** BTB_INDEX_WIDTH;
  localparam int unsigned TAG_WIDTH   = 30 - BTB_INDEX_WIDTH;

  logic                       btb_valid [BTB_ENTRIES];
  logic [TAG_WIDTH-1:0]       btb_tag   [BTB_ENTRIES];
  logic [31:0]                btb_tgt   [BTB_ENTRIES];
  logic [BTB_INDEX_WIDTH-1:0] btb_rd_idx;
  logic [BTB_INDEX_WIDTH-1:0] btb_wr_idx;
  logic                       btb_wr_en;

  assign btb_rd_idx     = in_fetch_pc[BTB_INDEX_WIDTH+1:2];
  assign btb_wr_idx     = in_rob_pc[BTB_INDEX_WIDTH+1:2];
  assign btb_wr_en      = rdy && in_rob_ce && in_rob_taken;
  assign out_btb_hit    = btb_valid[btb_rd_idx] &&
                          (btb_tag[btb_rd_idx] == in_fetch_pc[31:BTB_INDEX_WIDTH+2]);
  assign out_btb_target = out_btb_hit ? btb_tgt[btb_rd_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_wr_en) begin
      btb_valid[btb_wr_idx] <= 1'b1;
    end
  end

  // Tag and target need no reset; they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (!rst && btb_wr_en) begin
      btb_tag[btb_wr_idx] <= in_rob_pc[31:BTB_INDEX_WIDTH+2];
      btb_tgt[btb_wr_idx] <= in_rob_target;
    end
  end
`else
  assign out_btb_hit    = 1'b0;
  assign out_btb_target = 32'h0;
`endif

  logic unused_bits;
  assign unused_bits = ^{in_fetch_pc, in_rob_pc, in_rob_target, BTB_INDEX_WIDTH[0]};

endmodule

// File: tb/tb_bp_gshare.sv
// Bench for bp_gshare: directed literal checks plus randomized traffic against a behavioural model.
module tb_bp_gshare;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        in_fetch_ce;
  logic [31:0] in_fetch_pc;
  logic        out_pred_taken;
  logic [7:0]  out_pred_idx;
  logic        out_btb_hit;
  logic [31:0] out_btb_target;
  logic        in_rob_ce;
  logic [7:0]  in_rob_idx;
  logic        in_rob_taken;
  logic [31:0] in_rob_pc;
  logic [31:0] in_rob_target;
  logic        in_flush;

  int checks;
  int errors;
  bit cmp_en;

  bp_gshare #(
    .INDEX_WIDTH(8), .CNT_WIDTH(2), .HIST_WIDTH(8), .BTB_INDEX_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetch_ce(in_fetch_ce), .in_fetch_pc(in_fetch_pc),
    .out_pred_taken(out_pred_taken), .out_pred_idx(out_pred_idx),
    .out_btb_hit(out_btb_hit), .out_btb_target(out_btb_target),
    .in_rob_ce(in_rob_ce), .in_rob_idx(in_rob_idx), .in_rob_taken(in_rob_taken),
    .in_rob_pc(in_rob_pc), .in_rob_target(in_rob_target), .in_flush(in_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: counters as plain integers 0..3, histories as integers 0..255.
  int          m_pht [256];
  int          m_spec;
  int          m_commit;
  bit          m_bv  [64];
  logic [31:0] m_bpc [64];
  logic [31:0] m_btgt[64];

  function automatic int m_idx(logic [31:0] pc);
    return ((pc >> 2) & 255) ^ m_spec;
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_pht[m_idx(pc)] >= 2;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int e;
    e = (pc >> 2) & 63;
    return m_bv[e] && (m_bpc[e][31:8] == pc[31:8]);
  endfunction

  function automatic logic [31:0] m_tgt(logic [31:0] pc);
    return m_hit(pc) ? m_btgt[(pc >> 2) & 63] : 32'h0;
  endfunction

  function automatic int m_next_commit();
    return in_rob_ce ? (((m_commit * 2) + (in_rob_taken ? 1 : 0)) % 256) : m_commit;
  endfunction

  function automatic int m_trained(int c, bit taken);
    if (taken) return (c + 1 > 3) ? 3 : c + 1;
    return (c - 1 < 0) ? 0 : c - 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) m_pht[i] <= 1;
      for (int i = 0; i < 64; i++) m_bv[i] <= 1'b0;
      m_spec   <= 0;
      m_commit <= 0;
    end else if (rdy) begin
      if (in_rob_ce) begin
        m_pht[in_rob_idx] <= m_trained(m_pht[in_rob_idx], in_rob_taken);
`ifdef BP_BTB_EN
        if (in_rob_taken) begin
          m_bv[(in_rob_pc >> 2) & 63]   <= 1'b1;
          m_bpc[(in_rob_pc >> 2) & 63]  <= in_rob_pc;
          m_btgt[(in_rob_pc >> 2) & 63] <= in_rob_target;
        end
`endif
      end
      m_commit <= m_next_commit();
      if (in_flush) m_spec <= m_next_commit();
      else if (in_fetch_ce) m_spec <= ((m_spec * 2) + (m_taken(in_fetch_pc) ? 1 : 0)) % 256;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_idx", 32'(out_pred_idx), 32'(m_idx(in_fetch_pc)));
      chk("model_taken", 32'(out_pred_taken), 32'(m_taken(in_fetch_pc)));
      chk("model_btb_hit", 32'(out_btb_hit), 32'(m_hit(in_fetch_pc)));
      chk("model_btb_tgt", out_btb_target, m_tgt(in_fetch_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; in_fetch_ce = 1'b0; in_rob_ce = 1'b0; in_flush = 1'b0;
  endtask

  task automatic commit(input logic [7:0] idx, input bit taken);
    in_rob_ce = 1'b1; in_rob_idx = idx; in_rob_taken = taken;
    step();
    in_rob_ce = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic [7:0] e_idx, input bit e_taken);
    in_fetch_pc = pc;
    @(negedge clk);
    chk({name, "_idx"}, 32'(out_pred_idx), 32'(e_idx));
    chk({name, "_taken"}, 32'(out_pred_taken), 32'(e_taken));
  endtask

  initial begin
    checks = 0; errors = 0; cmp_en = 1'b0;
    idle();
    rst = 1'b1; in_fetch_pc = 32'h100; in_rob_idx = '0; in_rob_taken = 1'b0;
    in_rob_pc = '0; in_rob_target = '0;
    step(); step();
    idle();
    cmp_en = 1'b1;

    look("reset", 32'h100, 8'h40, 1'b0);
    chk("reset_btb_hit", 32'(out_btb_hit), 32'h0);
    chk("reset_btb_tgt", out_btb_target, 32'h0);

    commit(8'h40, 1'b1); commit(8'h40, 1'b1);
    look("two_taken", 32'h100, 8'h40, 1'b1);
    commit(8'h40, 1'b1);
    commit(8'h40, 1'b0);
    look("sat_top", 32'h100, 8'h40, 1'b1);
    commit(8'h40, 1'b0);
    look("down_to_01", 32'h100, 8'h40, 1'b0);
    repeat (3) commit(8'h40, 1'b0);
    commit(8'h40, 1'b1);
    look("sat_bottom", 32'h100, 8'h40, 1'b0);
    commit(8'h40, 1'b1);
    look("up_from_01", 32'h100, 8'h40, 1'b1);

    rst = 1'b1; step(); idle();
    commit(8'h40, 1'b1); commit(8'h40, 1'b1);
    commit(8'h41, 1'b1); commit(8'h41, 1'b1);
    commit(8'h43, 1'b1); commit(8'h43, 1'b1);
    in_fetch_pc = 32'h100; in_fetch_ce = 1'b1;
    repeat (3) step();
    in_fetch_ce = 1'b0;
    look("spec_111", 32'h100, 8'h47, 1'b0);

    repeat (7) commit(8'h10, 1'b0);
    commit(8'h10, 1'b1);
    in_rob_ce = 1'b1; in_rob_idx = 8'h20; in_rob_taken = 1'b1; in_flush = 1'b1; in_fetch_ce = 1'b1;
    step(); idle();
    look("flush_commit", 32'h100, 8'h43, 1'b1);
    in_rob_ce = 1'b1; in_rob_idx = 8'h20; in_rob_taken = 1'b0; in_flush = 1'b1;
    step(); idle();
    look("flush_nt", 32'h100, 8'h46, 1'b0);

    rdy = 1'b0; in_rob_ce = 1'b1; in_rob_idx = 8'h10; in_rob_taken = 1'b1;
    in_flush = 1'b1; in_fetch_ce = 1'b1;
    step(); idle();
    look("frozen_spec", 32'h100, 8'h46, 1'b0);
    look("frozen_pht", 32'h58, 8'h10, 1'b0);
    in_flush = 1'b1; step(); idle();
    look("frozen_commit", 32'h100, 8'h46, 1'b0);

    rst = 1'b1; in_rob_ce = 1'b1; in_rob_idx = 8'h40; in_rob_taken = 1'b1; in_flush = 1'b1;
    step(); idle();
    look("mid_reset", 32'h100, 8'h40, 1'b0);
    look("mid_reset_43", 32'h10C, 8'h43, 1'b0);

    in_rob_pc = 32'h200; in_rob_target = 32'h400;
    commit(8'h05, 1'b1);
    in_fetch_pc = 32'h200;
    @(negedge clk);
`ifdef BP_BTB_EN
    chk("btb_hit_200", 32'(out_btb_hit), 32'h1);
    chk("btb_tgt_200", out_btb_target, 32'h400);
`else
    chk("btb_hit_200", 32'(out_btb_hit), 32'h0);
    chk("btb_tgt_200", out_btb_target, 32'h0);
`endif
    in_fetch_pc = 32'h300;
    @(negedge clk);
    chk("btb_hit_300", 32'(out_btb_hit), 32'h0);
    chk("btb_tgt_300", out_btb_target, 32'h0);

    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom_range(0, 299) == 0);
      rdy           = ($urandom_range(0, 9) != 0);
      in_fetch_ce   = $urandom_range(0, 1);
      in_flush      = ($urandom_range(0, 15) == 0);
      in_rob_ce     = $urandom_range(0, 1);
      in_rob_taken  = ($urandom_range(0, 2) != 0);
      in_rob_idx    = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      in_rob_pc     = 32'(($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2));
      in_rob_target = $urandom;
      if ($urandom_range(0, 1) == 1)
        in_fetch_pc = 32'(($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2));
      else
        in_fetch_pc = $urandom;
      step();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_gshare.md
Name: bp_gshare

Overview:
- Parametrised gshare branch predictor; successor to the fixed-size 2-bit bimodal table.
- Table index = PC word-index XOR global history; configurable counter width and table depth.
- Keeps a speculative history for fetch and a committed history updated by the ROB; restores on flush.
- Sits between fetcher (lookup, combinational) and ROB commit (training, sequential).

Parameters:
- INDEX_WIDTH, 8, log2 of pattern-table entries (table has 2^INDEX_WIDTH counters)
- CNT_WIDTH, 2, saturating counter width, range 1..4
- HIST_WIDTH, 8, global history bits, 1..INDEX_WIDTH
- BTB_INDEX_WIDTH, 6, log2 of BTB entries (used only with BP_BTB_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- in_fetch_ce  in  1  fetcher lookup is valid and consumes a prediction this cycle
- in_fetch_pc  in  32  PC of the branch being looked up
- out_pred_taken  out  1  predicted direction (counter MSB)
- out_pred_idx  out  INDEX_WIDTH  table index used; fetcher carries it to the ROB
- out_btb_hit  out  1  BTB tag match (0 without BP_BTB_EN)
- out_btb_target  out  32  predicted target (0 without BP_BTB_EN)
- in_rob_ce  in  1  a conditional branch commits this cycle
- in_rob_idx  in  INDEX_WIDTH  index returned from out_pred_idx
- in_rob_taken  in  1  actual outcome
- in_rob_pc  in  32  committing branch PC (BTB only)
- in_rob_target  in  32  committing branch target (BTB only)
- in_flush  in  1  misprediction flush; restore speculative history

Behaviour:
- Index = in_fetch_pc[INDEX_WIDTH+1:2] XOR zero-extended spec_ghr. Combinational, zero latency.
- out_pred_taken = table[index][CNT_WIDTH-1]. out_pred_idx = index. Both are valid whenever in_fetch_pc is stable, irrespective of in_fetch_ce.
- Reset (rst=1 at posedge):
  - every counter is set to 2^(CNT_WIDTH-1)-1 (weakly not-taken; 01 for CNT_WIDTH=2);
  - spec_ghr = 0, commit_ghr = 0;
  - all BTB valid bits cleared.
- Reset wins over rdy and over all other inputs.
- Outputs after reset, with any PC: out_pred_taken=0, out_btb_hit=0, out_btb_target=0.
- When rdy=0, no state changes. Outputs still reflect the current state combinationally.
- Training, on posedge with rdy=1 and in_rob_ce=1:
  - taken: table[in_rob_idx] increments and saturates at 2^CNT_WIDTH-1;
  - not taken: decrements and saturates at 0;
  - commit_ghr <= {commit_ghr[HIST_WIDTH-2:0], in_rob_taken}. For HIST_WIDTH=1 it becomes in_rob_taken.
- Speculative history, on posedge with rdy=1:
  - if in_flush=1: spec_ghr <= next value of commit_ghr. This includes any same-cycle commit. in_fetch_ce is ignored that cycle.
  - else if in_fetch_ce=1: spec_ghr <= {spec_ghr[HIST_WIDTH-2:0], out_pred_taken}.
  - else: spec_ghr holds.
- Lookup and commit to the same index in the same cycle: the lookup sees the old counter (read-before-write). The write takes effect next cycle.
- The table is a single-write-port array. There is only one commit per cycle, so there is no write conflict.
- Counter arithmetic is done at CNT_WIDTH+1 bits or by explicit saturation compare. Wrap-around is forbidden.

Optional Feature:
- Macro: BP_BTB_EN.
- Defined: adds a direct-mapped BTB with 2^BTB_INDEX_WIDTH entries. Each entry holds valid, tag = pc[31:BTB_INDEX_WIDTH+2], and a 32-bit target.
  - Lookup indexes with in_fetch_pc[BTB_INDEX_WIDTH+1:2]. out_btb_hit = valid && tag match. out_btb_target = the stored target (0 on miss).
  - Write: on commit with in_rob_taken=1, the entry for in_rob_pc is written (valid=1, tag, in_rob_target), overwriting any previous entry.
  - Not-taken commits do not touch the BTB. Same-cycle read of the same entry returns old contents.
- Undefined: no BTB storage. out_btb_hit and out_btb_target are constant 0. in_rob_pc and in_rob_target are unused.

Test Plan:
- Reset then lookup pc=0x100, defaults -> out_pred_taken=0, out_pred_idx=0x40, out_btb_hit=0.
- Commit idx=0x40 taken twice with no fetches -> counter 01→10→11 and lookup pc=0x100 still gives idx=0x40^commit-independent (spec_ghr=0) taken=1. Third taken commit keeps 11. Four not-taken commits give 00, and a fifth keeps 00.
- Fetch ce with out_pred_taken=1 three times from reset -> spec_ghr=0b111. Lookup pc=0x100 gives idx=0x47.
- Spec_ghr=0b111, commit_ghr=0b01, same-cycle in_rob_ce taken plus in_flush=1 plus in_fetch_ce=1 -> commit_ghr=0b011, spec_ghr=0b011.
- rdy=0 with in_rob_ce=1, in_flush=1, in_fetch_ce=1 -> table, spec_ghr and commit_ghr are unchanged. Assert rst mid-stream -> all counters read 01 on the next cycle.
- BP_BTB_EN defined: commit taken pc=0x200 target=0x400, then lookup 0x200 -> hit=1, target=0x400. Lookup 0x300 (same BTB index when BTB_INDEX_WIDTH=6, different tag) -> hit=0, target=0. Undefined build -> hit and target are 0 throughout.
